ecc_frame_ctrl: RTL and testbench

Frame sequencer for the serial SECDED decoder. Accepts 16-bit extended-Hamming(16,11) codewords over a valid/ready handshake and clears the serial decoder. It then shifts the codeword into the decoder bit 0 first, captures the decoder's 5-bit syndrome {parity[3:0], check}, corrects or flags the frame, and presents 11 data bits plus status downstream. It sits between the frame source and the consumer, and owns all sequencing of the decoder.

---
 rtl/ecc_pkg.sv | 28 ++
 rtl/ecc_correct.sv | 31 +++
 rtl/ecc_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_ecc_frame_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared definitions for the SECDED frame controller: widths, status and FSM encodings,
// and the code positions that carry data bits.
package ecc_pkg;

    localparam int CW_W   = 16;
    localparam int DATA_W = 11;
    localparam int SYN_W  = 5;

    typedef enum logic [1:0] {
        ST_CLEAN     = 2'b00,
        ST_CORRECTED = 2'b01,
        ST_UNCORR    = 2'b10
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    // out_data[k] is taken from code position DATA_POS[k]
    localparam logic [3:0] DATA_POS [DATA_W] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

endpackage

// File: rtl/ecc_correct.sv
// Combinational SECDED correction: applies the decoder syndrome {parity[3:0], check}
// to the original codeword and extracts the 11 data bits plus a status code.
module ecc_correct
    import ecc_pkg::*;
(
    input  logic [CW_W-1:0]   cw_i,
    input  logic [SYN_W-1:0]  syn_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        status_o
);

    logic [CW_W-1:0] fixed_s;

    // A set check bit means a single error at position 'parity' (position 0 when parity is zero)
    always_comb begin
        fixed_s  = cw_i;
        status_o = ST_CLEAN;
        if (syn_i[0]) begin
            fixed_s[syn_i[4:1]] = ~cw_i[syn_i[4:1]];
            status_o            = ST_CORRECTED;
        end else if (syn_i[4:1] != 4'd0) begin
            status_o = ST_UNCORR;
        end else begin
            status_o = ST_CLEAN;
        end
        for (int k = 0; k < DATA_W; k++) begin
            data_o[k] = fixed_s[DATA_POS[k]];
        end
    end

endmodule

// File: rtl/ecc_frame_ctrl.sv
// Frame sequencer for the serial SECDED decoder: accept, clear, shift 16 bits LSB first,
// wait for the final syndrome, then hold the corrected result. Optional error counters
// are built when ECC_FRAME_CTRL_STATS_EN is defined.
module ecc_frame_ctrl
    import ecc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cw_valid,
    output logic              cw_ready,
    input  logic [15:0]       cw_data,
    output logic              dec_clr,
    output logic              dec_en,
    output logic              dec_datain,
    input  logic [4:0]        dec_syndrome,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [10:0]       out_data,
`ifdef ECC_FRAME_CTRL_STATS_EN
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
`endif
    output logic [1:0]        out_status
);

    state_e            state_q, state_d;
    logic [CW_W-1:0]   shreg_q, shreg_d;
    logic [CW_W-1:0]   cw_q, cw_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [1:0]        out_status_q, out_status_d;
    logic              cw_ready_q, dec_clr_q, dec_en_q, dec_datain_q, out_valid_q;
    logic [DATA_W-1:0] corr_data_s;
    logic [1:0]        corr_status_s;

    ecc_correct u_correct (
        .cw_i     (cw_q),
        .syn_i    (dec_syndrome),
        .data_o   (corr_data_s),
        .status_o (corr_status_s)
    );

    // Next-state logic; the result is latched on the WAIT -> HOLD transition
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cw_d         = cw_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_status_d = out_status_q;
        case (state_q)
            S_IDLE: begin
                if (cw_valid) begin
                    state_d = S_CLEAR;
                    shreg_d = cw_data;
                    cw_d    = cw_data;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: state_d = S_SHIFT;
            S_SHIFT: begin
                shreg_d = {1'b0, shreg_q[CW_W-1:1]};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_WAIT: begin
                state_d      = S_HOLD;
                out_data_d   = corr_data_s;
                out_status_d = corr_status_s;
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; outputs are decoded from the next state so they stay glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shreg_q      <= 16'h0000;
            cw_q         <= 16'h0000;
            cnt_q        <= 4'd0;
            out_data_q   <= 11'h000;
            out_status_q <= 2'b00;
            cw_ready_q   <= 1'b1;
            dec_clr_q    <= 1'b0;
            dec_en_q     <= 1'b0;
            dec_datain_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cw_q         <= cw_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_status_q <= out_status_d;
            cw_ready_q   <= (state_d == S_IDLE);
            dec_clr_q    <= (state_d == S_CLEAR);
            dec_en_q     <= (state_d == S_SHIFT);
            dec_datain_q <= (state_d == S_SHIFT) ? shreg_d[0] : 1'b0;
            out_valid_q  <= (state_d == S_HOLD);
        end
    end

    assign cw_ready   = cw_ready_q;
    assign dec_clr    = dec_clr_q;
    assign dec_en     = dec_en_q;
    assign dec_datain = dec_datain_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_status = out_status_q;

`ifdef ECC_FRAME_CTRL_STATS_EN
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

    // Saturating counters bumped as the result enters HOLD
    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (state_q == S_WAIT) begin
            if (corr_status_s == ST_CORRECTED && corr_cnt_q != {CNT_W{1'b1}}) begin
                corr_cnt_d = corr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (corr_status_s == ST_UNCORR && uncorr_cnt_q != {CNT_W{1'b1}}) begin
                uncorr_cnt_d = uncorr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                corr_cnt_d   = corr_cnt_q;
                uncorr_cnt_d = uncorr_cnt_q;
            end
        end else begin
            corr_cnt_d   = corr_cnt_q;
            uncorr_cnt_d = uncorr_cnt_q;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            corr_cnt_q   <= {CNT_W{1'b0}};
            uncorr_cnt_q <= {CNT_W{1'b0}};
        end else begin
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign corr_cnt   = corr_cnt_q;
    assign uncorr_cnt = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_ecc_frame_ctrl.sv
// Self-checking bench for ecc_frame_ctrl: behavioural serial decoder, timeline reference model,
// per-cycle compare process, directed test-plan frames and randomized frames.
module tb_ecc_frame_ctrl;

    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cw_valid = 1'b0;
    logic [15:0] cw_data = 16'h0000;
    logic        out_ready = 1'b0;
    logic        cw_ready, dec_clr, dec_en, dec_datain, out_valid;
    logic [4:0]  dec_syndrome;
    logic [10:0] out_data;
    logic [1:0]  out_status;
`ifdef ECC_FRAME_CTRL_STATS_EN
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    ecc_frame_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cw_valid     (cw_valid),
        .cw_ready     (cw_ready),
        .cw_data      (cw_data),
        .dec_clr      (dec_clr),
        .dec_en       (dec_en),
        .dec_datain   (dec_datain),
        .dec_syndrome (dec_syndrome),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
`ifdef ECC_FRAME_CTRL_STATS_EN
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt),
`endif
        .out_status   (out_status)
    );

    always #5 clk = ~clk;

    // Serial decoder: accumulates XOR of set-bit positions and overall parity
    logic [3:0] dpar = 4'd0;
    logic       dchk = 1'b0;
    logic [3:0] dpos = 4'd0;
    always @(posedge clk) begin
        if (dec_clr) begin
            dpar <= 4'd0; dchk <= 1'b0; dpos <= 4'd0;
        end else if (dec_en) begin
            if (dec_datain) begin
                dpar <= dpar ^ dpos; dchk <= ~dchk;
            end
            dpos <= dpos + 4'd1;
        end
    end
    assign dec_syndrome = {dpar, dchk};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the code rules: {status, data}
    function automatic logic [12:0] ref_decode(input logic [15:0] cw);
        int syn = 0;
        int par = 0;
        int k = 0;
        logic [15:0] fixed;
        logic [1:0]  st;
        logic [10:0] d;
        for (int i = 0; i < 16; i++) if (cw[i]) begin syn ^= i; par ^= 1; end
        fixed = cw;
        if (par == 1) begin fixed[syn] = ~fixed[syn]; st = 2'b01; end
        else if (syn != 0) st = 2'b10;
        else st = 2'b00;
        d = 11'h000;
        for (int i = 1; i < 16; i++) if ((i & (i - 1)) != 0) begin d[k] = fixed[i]; k++; end
        return {st, d};
    endfunction

    function automatic logic [15:0] make_cw(input logic [10:0] d);
        logic [15:0] cw = 16'h0000;
        int k = 0;
        int syn = 0;
        for (int i = 1; i < 16; i++) if ((i & (i - 1)) != 0) begin cw[i] = d[k]; k++; end
        for (int i = 0; i < 16; i++) if (cw[i]) syn ^= i;
        for (int b = 0; b < 4; b++) if (syn[b]) cw[1 << b] = 1'b1;
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    // Timeline model: t_m = cycles since the accepting edge (0 = idle, 19 = holding)
    int          t_m = 0;
    logic [15:0] cw_m = 16'h0000;
    logic [10:0] last_data = 11'h000;
    logic [1:0]  last_stat = 2'b00;
    int          corr_m = 0;
    int          uncorr_m = 0;
    always @(posedge clk) begin
        logic [12:0] r;
        if (!rst_n) begin
            t_m = 0; last_data = 11'h000; last_stat = 2'b00; corr_m = 0; uncorr_m = 0;
        end else if (t_m == 0) begin
            if (cw_valid) begin cw_m = cw_data; t_m = 1; end
        end else if (t_m < 18) begin
            t_m++;
        end else if (t_m == 18) begin
            t_m = 19;
            r = ref_decode(cw_m);
            last_data = r[10:0];
            last_stat = r[12:11];
            if (r[12:11] == 2'b01 && corr_m < 65535) corr_m++;
            if (r[12:11] == 2'b10 && uncorr_m < 65535) uncorr_m++;
        end else if (out_ready) begin
            t_m = 0;
        end
    end

    // Per-cycle compare on the falling edge
    always @(negedge clk) begin
        if (checking) begin
            chk("cw_ready", cw_ready, (t_m == 0));
            chk("dec_clr", dec_clr, (t_m == 1));
            chk("dec_en", dec_en, (t_m >= 2 && t_m <= 17));
            chk("dec_datain", dec_datain, (t_m >= 2 && t_m <= 17) ? cw_m[t_m-2] : 1'b0);
            chk("out_valid", out_valid, (t_m == 19));
            chk("out_data", out_data, last_data);
            chk("out_status", out_status, last_stat);
`ifdef ECC_FRAME_CTRL_STATS_EN
            chk("corr_cnt", corr_cnt, corr_m);
            chk("uncorr_cnt", uncorr_cnt, uncorr_m);
`endif
        end
    end

    task automatic run_frame(input logic [15:0] cw, input int hold_low,
                             output logic [10:0] d, output logic [1:0] s, output int lat);
        int n = 0;
        cw_data = cw; cw_valid = 1'b1;
        while (!cw_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        cw_valid = 1'b0; cw_data = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        d = out_data; s = out_status;
        repeat (hold_low) begin
            @(posedge clk); #1;
            chk("hold_data_stable", out_data, d);
            chk("hold_status_stable", out_status, s);
            chk("hold_valid_stable", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [15:0] cw, input int hold_low,
                            input logic [10:0] ed, input logic [1:0] es);
        logic [10:0] d; logic [1:0] s; int lat;
        run_frame(cw, hold_low, d, s, lat);
        chk({name, "_latency"}, lat, 19);
        chk({name, "_data"}, d, ed);
        chk({name, "_status"}, s, es);
    endtask

    initial begin
        logic [10:0] d; logic [1:0] s; int lat;
        logic [15:0] cw;
        int p1, p2, nflip;

        chk("pin_model_002F", ref_decode(16'h002F), {2'b01, 11'h001});
        chk("pin_model_006F", ref_decode(16'h006F), {2'b10, 11'h007});
        chk("pin_model_000E", ref_decode(16'h000E), {2'b01, 11'h001});
        chk("pin_make_cw", make_cw(11'h001), 16'h000F);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_cw_ready", cw_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 11'h000);
        checking = 1'b1;

        directed("zero", 16'h0000, 0, 11'h000, 2'b00);
        directed("valid1", 16'h000F, 0, 11'h001, 2'b00);
        directed("flip5", 16'h002F, 0, 11'h001, 2'b01);
`ifdef ECC_FRAME_CTRL_STATS_EN
        chk("corr_cnt_one", corr_cnt, 1);
`endif
        directed("flip56", 16'h006F, 0, 11'h007, 2'b10);
`ifdef ECC_FRAME_CTRL_STATS_EN
        chk("uncorr_cnt_one", uncorr_cnt, 1);
`endif
        directed("flip0", 16'h000E, 0, 11'h001, 2'b01);
        directed("backpressure", 16'h002F, 5, 11'h001, 2'b01);

        // Reset in the middle of SHIFT (count 7 = cycle 9 after accept)
        cw_data = 16'h00FF; cw_valid = 1'b1;
        @(posedge clk); #1;
        cw_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_cw_ready", cw_ready, 1'b1);
        chk("midreset_out_valid", out_valid, 1'b0);
        repeat (25) begin @(posedge clk); #1; end
        directed("after_reset", 16'h000F, 0, 11'h001, 2'b00);

        for (int f = 0; f < 40; f++) begin
            cw = make_cw(11'($urandom));
            nflip = $urandom_range(0, 2);
            p1 = $urandom_range(0, 15);
            p2 = (p1 + $urandom_range(1, 15)) % 16;
            if (nflip >= 1) cw[p1] = ~cw[p1];
            if (nflip == 2) cw[p2] = ~cw[p2];
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            run_frame(cw, $urandom_range(0, 4), d, s, lat);
            chk("rand_latency", lat, 19);
        end

        repeat (3) begin @(posedge clk); #1; end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
